// File: rtl/spi_pkg.sv
// Shared types and default parameters for the arbitrated SPI master.
package spi_pkg;

   localparam int   SPI_NUM_REQ_DEF    = 4;
   localparam int   SPI_DATA_WIDTH_DEF = 8;
   localparam int   SPI_CLK_DIV_DEF    = 2;
   localparam logic SPI_IDLE_VAL_DEF   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_HOLD     = 3'd4,
      ST_GAP      = 3'd5
   } spi_mst_state_t;

endpackage

// File: rtl/spi_bus.sv
// SPI bus bundle; Mode 3 (sclk idles high, slave samples on the rising edge).
interface spi_bus;
   logic sclk;
   logic cs_n;
   logic mosi;

   modport master (output sclk, output cs_n, output mosi);
   modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   always_comb begin
      int         cand;
      logic [IDX_W-1:0] cand_idx;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin shared SPI master (Mode 3, MSB first, transmit only).
//
//  state       | meaning
//  ------------+---------------------------------------------------
//  ST_IDLE     | bus idle, grant one requester when any is valid
//  ST_SETUP    | cs_n low, sclk high, before the first bit
//  ST_SHIFT_LO | sclk low, current bit presented on mosi
//  ST_SHIFT_HI | sclk high, slave samples on the rising edge
//  ST_HOLD     | cs_n low after the last bit
//  ST_GAP      | cs_n high inter-frame gap, done on its last cycle
module spi_master_arbiter
   import spi_pkg::*;
#(
   parameter  int   NUM_REQ    = SPI_NUM_REQ_DEF,
   parameter  int   DATA_WIDTH = SPI_DATA_WIDTH_DEF,
   parameter  int   CLK_DIV    = SPI_CLK_DIV_DEF,
   parameter  logic IDLE_VAL   = SPI_IDLE_VAL_DEF,
   localparam int   IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic                                 done,
   output logic [IDX_W-1:0]                     done_id,
   spi_bus.master                               spi_bus_0
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_WIDTH - 1);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_master_arbiter: CLK_DIV must be at least 1");
   end
   if (DATA_WIDTH < 2) begin : g_bad_data_width
      $error("spi_master_arbiter: DATA_WIDTH must be at least 2");
   end
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("spi_master_arbiter: NUM_REQ must be in 2..16");
   end

   spi_mst_state_t          state_q, state_d;
   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]        last_grant_q, last_grant_d;
   logic                    cs_n_q, cs_n_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;

   logic [NUM_REQ-1:0]      arb_grant;
   logic [IDX_W-1:0]        arb_idx;
   logic                    arb_valid;
   logic                    div_tc;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign div_tc = (div_cnt_q == '0);

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;

      if (state_q != ST_IDLE && !div_tc) begin
         div_cnt_d = div_cnt_q - DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d      = ST_SETUP;
               div_cnt_d    = DIV_LOAD;
               bit_cnt_d    = BIT_LOAD;
               shift_d      = req_data[arb_idx];
               grant_idx_d  = arb_idx;
               last_grant_d = arb_idx;
            end
         end
         ST_SETUP: begin
            if (div_tc) begin
               state_d   = ST_SHIFT_LO;
               div_cnt_d = DIV_LOAD;
            end
         end
         ST_SHIFT_LO: begin
            if (div_tc) begin
               state_d   = ST_SHIFT_HI;
               div_cnt_d = DIV_LOAD;
            end
         end
         ST_SHIFT_HI: begin
            if (div_tc) begin
               div_cnt_d = DIV_LOAD;
               if (bit_cnt_q == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d   = ST_SHIFT_LO;
                  bit_cnt_d = bit_cnt_q - BIT_W'(1);
                  shift_d   = {shift_q[DATA_WIDTH-2:0], IDLE_VAL};
               end
            end
         end
         ST_HOLD: begin
            if (div_tc) begin
               state_d   = ST_GAP;
               div_cnt_d = DIV_LOAD;
            end
         end
         ST_GAP: begin
            if (div_tc) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pin levels follow the next state so they change on the same edge as the FSM.
   always_comb begin
      cs_n_d = !(state_d inside {ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD});
      sclk_d = (state_d != ST_SHIFT_LO);
      mosi_d = (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) ?
               shift_d[DATA_WIDTH-1] : IDLE_VAL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         grant_idx_q  <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b1;
         mosi_q       <= IDLE_VAL;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
         cs_n_q       <= cs_n_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
   assign done      = (state_q == ST_GAP) && div_tc;
   assign done_id   = grant_idx_q;

   assign spi_bus_0.sclk = sclk_q;
   assign spi_bus_0.cs_n = cs_n_q;
   assign spi_bus_0.mosi = mosi_q;

endmodule
